// File: rtl/dmem_refill_ctrl.sv
// D-cache refill controller: optionally writes back the resident block over a
// single-word req/ack memory port, then refills the cache with the requested block.
module dmem_refill_ctrl #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NEED_change_cache,
  input  logic        NEED_WB_cache,
  input  logic [31:0] NEED_Base_Addr,
  input  logic [31:0] NEED_High_Addr,
  output logic [31:0] NEED_Addr,
  output logic [31:0] NEED_Din,
  input  logic [31:0] NEED_Dout,
  output logic        NEED_WE,
  output logic        NEED_Done,
  output logic        MM_Req,
  output logic        MM_WE,
  output logic [31:0] MM_Addr,
  output logic [31:0] MM_Wdata,
  input  logic [31:0] MM_Rdata,
  input  logic        MM_Ack,
  output logic [2:0]  dbg_state_o
);

  // Memory handshake: MM_Req rises together with MM_WE/MM_Addr/MM_Wdata and all
  // four hold until a cycle with MM_Ack high; MM_Ack while MM_Req is low is ignored.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_RD    = 3'd1,
    WB_REQ   = 3'd2,
    FILL_REQ = 3'd3,
    FILL_WR  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] idx_q, idx_d;
  logic [31:0] cur_base_q, cur_base_d;
  logic        cur_valid_q, cur_valid_d;
  logic [31:0] req_base_q, req_base_d;
  logic [31:0] need_addr_q, need_addr_d;
  logic [31:0] need_din_q, need_din_d;
  logic        need_we_q, need_we_d;
  logic        need_done_q, need_done_d;
  logic        mm_req_q, mm_req_d;
  logic        mm_we_q, mm_we_d;
  logic [31:0] mm_addr_q, mm_addr_d;
  logic [31:0] mm_wdata_q, mm_wdata_d;

  logic [AW:0] idx_inc;
  logic [31:0] idx_ext, idx_inc_ext;
  logic        last_word;
  logic        mm_done;
  logic        unused_high;

  assign idx_inc     = idx_q + (AW+1)'(1);
  assign idx_ext     = {{(31-AW){1'b0}}, idx_q};
  assign idx_inc_ext = {{(31-AW){1'b0}}, idx_inc};
  assign last_word   = (idx_q == (AW+1)'(WORDS-1));
  assign mm_done     = mm_req_q && MM_Ack;
  assign unused_high = ^NEED_High_Addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cur_base_q  <= '0;
      cur_valid_q <= 1'b0;
      req_base_q  <= '0;
      need_addr_q <= '0;
      need_din_q  <= '0;
      need_we_q   <= 1'b0;
      need_done_q <= 1'b0;
      mm_req_q    <= 1'b0;
      mm_we_q     <= 1'b0;
      mm_addr_q   <= '0;
      mm_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_base_q  <= cur_base_d;
      cur_valid_q <= cur_valid_d;
      req_base_q  <= req_base_d;
      need_addr_q <= need_addr_d;
      need_din_q  <= need_din_d;
      need_we_q   <= need_we_d;
      need_done_q <= need_done_d;
      mm_req_q    <= mm_req_d;
      mm_we_q     <= mm_we_d;
      mm_addr_q   <= mm_addr_d;
      mm_wdata_q  <= mm_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (NEED_change_cache)
                  state_d = (NEED_WB_cache && cur_valid_q) ? WB_RD : FILL_REQ;
      WB_RD:    state_d = WB_REQ;
      WB_REQ:   if (mm_done) state_d = last_word ? FILL_REQ : WB_RD;
      FILL_REQ: if (mm_done) state_d = FILL_WR;
      FILL_WR:  state_d = last_word ? DONE : FILL_REQ;
      DONE:     if (!NEED_change_cache) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d       = idx_q;
    cur_base_d  = cur_base_q;
    cur_valid_d = cur_valid_q;
    req_base_d  = req_base_q;
    need_addr_d = need_addr_q;
    need_din_d  = need_din_q;
    need_we_d   = 1'b0;
    need_done_d = need_done_q;
    mm_req_d    = mm_req_q;
    mm_we_d     = mm_we_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    unique case (state_q)
      IDLE: begin
        need_done_d = 1'b0;
        if (NEED_change_cache) begin
          req_base_d = NEED_Base_Addr;
          idx_d      = '0;
          if (NEED_WB_cache && cur_valid_q) begin
            need_addr_d = '0;
          end else begin
            // Issue the first read on entry so a zero-wait word takes 3 cycles.
            mm_req_d  = 1'b1;
            mm_we_d   = 1'b0;
            mm_addr_d = NEED_Base_Addr;
          end
        end
      end
      WB_RD: need_addr_d = idx_ext;
      WB_REQ: begin
        // NEED_Dout holds the word addressed in WB_RD during this state's first cycle.
        if (!mm_req_q) begin
          mm_wdata_d = NEED_Dout;
          mm_addr_d  = cur_base_q + idx_ext;
          mm_we_d    = 1'b1;
          mm_req_d   = 1'b1;
        end else if (MM_Ack) begin
          mm_req_d = 1'b0;
          if (last_word) begin
            idx_d = '0;
          end else begin
            idx_d       = idx_inc;
            need_addr_d = idx_inc_ext;
          end
        end
      end
      FILL_REQ: begin
        if (!mm_req_q) begin
          mm_req_d  = 1'b1;
          mm_we_d   = 1'b0;
          mm_addr_d = req_base_q + idx_ext;
        end else if (MM_Ack) begin
          mm_req_d    = 1'b0;
          need_addr_d = idx_ext;
          need_din_d  = MM_Rdata;
          need_we_d   = 1'b1;
        end
      end
      FILL_WR: begin
        idx_d = idx_inc;
        if (last_word) begin
          cur_base_d  = req_base_q;
          cur_valid_d = 1'b1;
          need_done_d = 1'b1;
        end else begin
          mm_req_d  = 1'b1;
          mm_we_d   = 1'b0;
          mm_addr_d = req_base_q + idx_inc_ext;
        end
      end
      DONE: if (!NEED_change_cache) need_done_d = 1'b0;
      default: ;
    endcase
  end

  assign NEED_Addr   = need_addr_q;
  assign NEED_Din    = need_din_q;
  assign NEED_WE     = need_we_q;
  assign NEED_Done   = need_done_q;
  assign MM_Req      = mm_req_q;
  assign MM_WE       = mm_we_q;
  assign MM_Addr     = mm_addr_q;
  assign MM_Wdata    = mm_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_refill_ctrl.sv
// Bench for dmem_refill_ctrl with a 4-word block: cache and memory responders,
// a table of refill requests, and directed reset-abort / stray-ack sequences.
module tb_dmem_refill_ctrl;
  localparam int WORDS = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        NEED_change_cache, NEED_WB_cache;
  logic [31:0] NEED_Base_Addr, NEED_High_Addr;
  logic [31:0] NEED_Addr, NEED_Din, NEED_Dout;
  logic        NEED_WE, NEED_Done;
  logic        MM_Req, MM_WE, MM_Ack;
  logic [31:0] MM_Addr, MM_Wdata, MM_Rdata;
  logic [2:0]  dbg_state;

  logic        mdl_ack, stray_ack;
  int          ack_delay, wait_cnt;
  logic [31:0] cache_m [WORDS];
  logic [64:0] act_mm_q[$];
  logic [63:0] act_cw_q[$];
  int          n_cmp, n_bad;

  assign MM_Ack = mdl_ack | stray_ack;

  dmem_refill_ctrl #(.WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .NEED_change_cache(NEED_change_cache), .NEED_WB_cache(NEED_WB_cache),
    .NEED_Base_Addr(NEED_Base_Addr), .NEED_High_Addr(NEED_High_Addr),
    .NEED_Addr(NEED_Addr), .NEED_Din(NEED_Din), .NEED_Dout(NEED_Dout),
    .NEED_WE(NEED_WE), .NEED_Done(NEED_Done),
    .MM_Req(MM_Req), .MM_WE(MM_WE), .MM_Addr(MM_Addr), .MM_Wdata(MM_Wdata),
    .MM_Rdata(MM_Rdata), .MM_Ack(MM_Ack), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cache port B (registered read) and main memory with a programmable ack delay.
  always @(posedge clk) begin
    if (NEED_WE) begin
      cache_m[NEED_Addr[AW-1:0]] <= NEED_Din;
      act_cw_q.push_back({NEED_Addr, NEED_Din});
    end
    NEED_Dout <= cache_m[NEED_Addr[AW-1:0]];
    if (mdl_ack) begin
      mdl_ack <= 1'b0;
    end else if (MM_Req) begin
      if (wait_cnt >= ack_delay - 1) begin
        mdl_ack  <= 1'b1;
        wait_cnt <= 0;
        MM_Rdata <= rd_data(MM_Addr);
        act_mm_q.push_back({MM_WE, MM_Addr, MM_WE ? MM_Wdata : rd_data(MM_Addr)});
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // Protocol watch: request fields stable until ack, NEED_WE never wider than a cycle.
  logic        held, prev_we, prev_mwe;
  logic [31:0] prev_maddr, prev_mwdata;
  always @(negedge clk) begin
    if (held) begin
      chk("req_held", MM_Req, 1'b1);
      chk("addr_stable", MM_Addr, prev_maddr);
      chk("we_stable", MM_WE, prev_mwe);
      if (prev_mwe) chk("wdata_stable", MM_Wdata, prev_mwdata);
    end
    if (NEED_WE) chk("need_we_single", prev_we, 1'b0);
    held        = MM_Req && !MM_Ack && !rst;
    prev_we     = NEED_WE && !rst;
    prev_maddr  = MM_Addr;
    prev_mwe    = MM_WE;
    prev_mwdata = MM_Wdata;
  end

  task automatic run_req(input logic [31:0] base, input logic wb, input int delay,
                         output int lat);
    ack_delay = delay;
    @(negedge clk);
    NEED_change_cache = 1'b1;
    NEED_WB_cache     = wb;
    NEED_Base_Addr    = base;
    NEED_High_Addr    = base + 32'(WORDS - 1);
    @(negedge clk);
    NEED_Base_Addr = ~base;
    NEED_WB_cache  = ~wb;
    lat = 0;
    while (!NEED_Done && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("done_rise", NEED_Done, 1'b1);
    repeat (2) @(negedge clk);
    chk("done_hold", NEED_Done, 1'b1);
    NEED_change_cache = 1'b0;
    @(negedge clk);
    chk("done_fall", NEED_Done, 1'b0);
  endtask

  task automatic verify_run(input logic [31:0] base, input logic exp_wb,
                            input logic [31:0] wb_base);
    logic [64:0] exp_q[$];
    logic [63:0] exp_cw[$];
    for (int i = 0; i < WORDS; i++)
      if (exp_wb) exp_q.push_back({1'b1, 32'(wb_base + 32'(i)), rd_data(wb_base + 32'(i))});
    for (int i = 0; i < WORDS; i++) begin
      exp_q.push_back({1'b0, 32'(base + 32'(i)), rd_data(base + 32'(i))});
      exp_cw.push_back({32'(i), rd_data(base + 32'(i))});
    end
    chk("mm_count", act_mm_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < act_mm_q.size()) chk("mm_txn", act_mm_q[k], exp_q[k]);
    chk("cache_wr_count", act_cw_q.size(), exp_cw.size());
    for (int k = 0; k < exp_cw.size(); k++)
      if (k < act_cw_q.size()) chk("cache_wr", act_cw_q[k], exp_cw[k]);
    act_mm_q.delete();
    act_cw_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_need_addr"}, NEED_Addr, 0);
    chk({tag, "_need_din"}, NEED_Din, 0);
    chk({tag, "_need_we"}, NEED_WE, 0);
    chk({tag, "_need_done"}, NEED_Done, 0);
    chk({tag, "_mm_req"}, MM_Req, 0);
    chk({tag, "_mm_we"}, MM_WE, 0);
    chk({tag, "_mm_addr"}, MM_Addr, 0);
    chk({tag, "_mm_wdata"}, MM_Wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic        wb;
    int          delay;
    logic        exp_wb;
    logic [31:0] wb_base;
    int          exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, guard;
    n_cmp = 0; n_bad = 0;
    mdl_ack = 1'b0; stray_ack = 1'b0; ack_delay = 1; wait_cnt = 0;
    held = 1'b0; prev_we = 1'b0; prev_mwe = 1'b0; prev_maddr = '0; prev_mwdata = '0;
    NEED_change_cache = 1'b0; NEED_WB_cache = 1'b0;
    NEED_Base_Addr = '0; NEED_High_Addr = '0;

    // Latency 12 = 3 cycles per word for a zero-wait, no-write-back refill; -1 = unchecked.
    vecs[0] = '{32'h0000_0400, 1'b0, 1, 1'b0, 32'h0,         12};
    vecs[1] = '{32'h0000_0800, 1'b1, 1, 1'b1, 32'h0000_0400, -1};
    vecs[2] = '{32'h0000_0C00, 1'b1, 5, 1'b1, 32'h0000_0800, -1};
    vecs[3] = '{32'hFFFF_FFFC, 1'b0, 1, 1'b0, 32'h0,         12};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Stray ack in IDLE must not start anything.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("stray_ack");
    chk("stray_ack_no_txn", act_mm_q.size(), 0);

    for (int v = 0; v < 4; v++) begin
      run_req(vecs[v].base, vecs[v].wb, vecs[v].delay, lat);
      if (vecs[v].exp_lat >= 0) chk("latency", lat, vecs[v].exp_lat);
      verify_run(vecs[v].base, vecs[v].exp_wb, vecs[v].wb_base);
    end

    // Reset during the second FILL_REQ, then a dirty request must skip write-back.
    ack_delay = 1;
    @(negedge clk);
    NEED_change_cache = 1'b1; NEED_WB_cache = 1'b0; NEED_Base_Addr = 32'h0000_0400;
    guard = 0;
    while (!(act_cw_q.size() == 1 && MM_Req) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_fill2", guard < 200, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    rst = 1'b0;
    NEED_change_cache = 1'b0;
    repeat (3) @(negedge clk);
    act_mm_q.delete();
    act_cw_q.delete();
    run_req(32'h0000_0800, 1'b1, 1, lat);
    chk("post_reset_latency", lat, 12);
    verify_run(32'h0000_0800, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
